div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divide unit for the execute stage; it executes DIV, DIVU, REM and REMU, which the single-cycle ALU does not implement. It takes the same operand_a/operand_b pair the ALU receives and decodes a one-hot select in the same style. It runs a radix-2 restoring division, one quotient bit per cycle, and returns one WIDTH-bit result with a done pulse. Downstream, the execute writeback mux takes that result in place of the ALU result. The pipeline stalls while busy is high.

## Interface
- WIDTH, 32, datapath width; quotient/remainder width; iteration count.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- div_sel_div  in  1  signed quotient.
- div_sel_divu  in  1  unsigned quotient.
- div_sel_rem  in  1  signed remainder.
- div_sel_remu  in  1  unsigned remainder.
- operand_a  in  WIDTH  dividend; captured on accepted start.
- operand_b  in  WIDTH  divisor; captured on accepted start.
- flush  in  1  synchronous kill of the operation in flight.
- busy  out  1  high while in CALC or FIN.
- done  out  1  single-cycle pulse; result valid.
- result  out  WIDTH  registered result; held until the next done.

## Operation
- One clock, clk. Reset is asynchronous and active-low on rst_n. Reset values: state IDLE, busy 0, done 0, result 0, all internal registers 0.
- States are IDLE, CALC and FIN.
- **IDLE.**
  - A start is accepted when start=1, exactly one select is high and flush=0.
  - A start with zero selects is ignored.
  - A start with more than one select is illegal; the bench asserts against it.
- **Capture on accepted start.**
  - Register the operation.
  - Register sign_q = a[W-1]^b[W-1] and sign_r = a[W-1]. Both apply to signed ops only; both are 0 for unsigned ops.
  - Register |a| and |b| for signed ops, or raw a and b for unsigned ops.
  - Clear the partial remainder. Set the counter to WIDTH-1.
- **Fast path on accepted start.**
  - Divide by zero (b==0): result is all-ones for DIV/DIVU and a for REM/REMU.
  - Signed overflow (DIV/REM with a=0x80000000 and b=0xFFFFFFFF): result is 0x80000000 for DIV and 0 for REM.
  - The fast path loads result directly and pulses done next cycle. State stays IDLE and busy stays 0.
- **CALC, once per cycle.**
  - Shift the {remainder, quotient} pair left by 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor. If there is no borrow, keep the difference and set the quotient LSB to 1. Otherwise keep the remainder and set the quotient LSB to 0.
  - The subtract is WIDTH+1 bits wide to catch the borrow.
  - When the counter reaches 0, go to FIN. Otherwise decrement the counter.
- **FIN.**
  - Register the result: quotient, negated (two's complement) if sign_q; or remainder, negated if sign_r.
  - Pulse done. Return to IDLE.
- **Flush.** In any state, flush=1 returns the unit to IDLE at the next edge with no done and result unchanged. If flush and start are high together, flush wins and the start is dropped.
- start while busy=1 is ignored, with no queuing.
- Operands may change after acceptance without effect on the operation in flight.

## Timing
- Name the cycles relative to the cycle in which an accepted start is high (cycle 0).
- Normal path:
  - busy is high in cycles 1..WIDTH+1: CALC in 1..WIDTH, FIN in WIDTH+1.
  - done is high and result is valid in cycle WIDTH+2 (cycle 34 for WIDTH=32), with busy=0.
- Fast path: done is high and result is valid in cycle 1; busy is never high.
- A new start is accepted in the same cycle done is high (back-to-back operation).
- done is never high for two consecutive cycles from one start.
- Flush in cycle k: busy is 0 in cycle k+1.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous), with no done.

## Test plan
- **DIVU 100/7.** Start in cycle 0 → done only in cycle 34, result 14, busy high in cycles 1-33. Repeating with REMU → result 2.
- **Signed DIV -7/2** (0xFFFFFFF9, 2) → result 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). REM 7/-2 → 1.
- **Divide by zero.**
  - DIVU 5/0 → 0xFFFFFFFF. DIV -5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
  - Each has done in cycle 1 and busy never high.
- **Signed overflow.** DIV 0x80000000/0xFFFFFFFF → 0x80000000, done in cycle 1. REM with the same operands → 0.
- **Flush.**
  - Start DIVU at cycle 0, flush at cycle 10 → busy low in cycle 11, no done, result unchanged.
  - A new start in cycle 12 completes normally with done in cycle 46.
- **Start, reset and back-to-back control.**
  - A start pulsed in cycle 5 during an operation is ignored.
  - rst_n low mid-CALC → busy, done and result are 0 immediately.
  - A start in the done cycle is accepted, and its done follows WIDTH+2 cycles later.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_sel_div,
    input  logic             div_sel_divu,
    input  logic             div_sel_rem,
    input  logic             div_sel_remu,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_next;
    logic             op_rem;
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] quo, dvs, rem;
    logic [CW-1:0]    cnt;

    logic [3:0]       sel;
    logic             sel_one, accept, is_signed, is_rem;
    logic             b_zero, ovf, fast;
    logic [WIDTH-1:0] abs_a, abs_b, fast_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic [WIDTH-1:0] q_out, r_out;
    logic             unused_bits;

    assign sel       = {div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu};
    assign sel_one   = (sel != 4'b0) && ((sel & (sel - 4'd1)) == 4'b0);
    assign accept    = start && sel_one && !flush && (state == IDLE);
    assign is_signed = div_sel_div | div_sel_rem;
    assign is_rem    = div_sel_rem | div_sel_remu;

    assign abs_a = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign abs_b = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Divide-by-zero and most-negative / -1 bypass the iteration entirely
    assign b_zero   = (operand_b == '0);
    assign ovf      = is_signed && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
    assign fast     = b_zero || ovf;
    assign fast_res = b_zero ? (is_rem ? operand_a : '1) : (is_rem ? '0 : operand_a);

    // Shift in the next dividend bit and trial-subtract; MSB of trial is the borrow
    assign shifted     = {rem, quo[WIDTH-1]};
    assign trial       = {1'b0, shifted} - {2'b0, dvs};
    assign borrow      = trial[WIDTH+1];
    // When the difference is kept it is below the divisor, so this bit is always 0
    assign unused_bits = trial[WIDTH];

    assign q_out = sign_q ? -quo : quo;
    assign r_out = sign_r ? -rem : rem;

    assign busy = (state == CALC) || (state == FIN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: flush always wins back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !fast) state_next = CALC;
            CALC: begin
                if (flush)            state_next = IDLE;
                else if (cnt == '0)   state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, result and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rem <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_rem <= is_rem;
                sign_q <= is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                sign_r <= is_signed & operand_a[WIDTH-1];
                quo    <= abs_a;
                dvs    <= abs_b;
                rem    <= '0;
                cnt    <= CW'(WIDTH-1);
                if (fast) begin
                    result <= fast_res;
                    done   <= 1'b1;
                end
            end else if (state == CALC && !flush) begin
                rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ~borrow};
                if (cnt != '0) cnt <= cnt - CW'(1);
            end else if (state == FIN && !flush) begin
                result <= op_rem ? r_out : q_out;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random scoreboard bench for div_unit
module tb_div_unit;
    localparam int W = 32;
    localparam logic [3:0] DIV = 4'b1000, DIVU = 4'b0100, REM = 4'b0010, REMU = 4'b0001;

    logic         clk = 0, rst_n = 1, start = 0, flush = 0;
    logic         sel_div = 0, sel_divu = 0, sel_rem = 0, sel_remu = 0;
    logic [W-1:0] operand_a = 0, operand_b = 0;
    logic         busy, done;
    logic [W-1:0] result;

    int           checks = 0, errors = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] last_res = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .div_sel_div(sel_div), .div_sel_divu(sel_divu),
        .div_sel_rem(sel_rem), .div_sel_remu(sel_remu),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) begin
            assert ($countones({sel_div, sel_divu, sel_rem, sel_remu}) <= 1)
            else begin
                errors++;
                $error("FAIL illegal_sel: observed %b expected at most one select", {sel_div, sel_divu, sel_rem, sel_remu});
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_sel(input logic [3:0] s);
        {sel_div, sel_divu, sel_rem, sel_remu} = s;
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic sgn, isrem;
        sgn   = s[3] | s[1];
        isrem = s[1] | s[0];
        if (b == 0) return isrem ? a : '1;
        if (sgn && a == 32'h8000_0000 && b == '1) return isrem ? '0 : a;
        if (sgn) return isrem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        return isrem ? a % b : a / b;
    endfunction

    function automatic int lat_of(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0 || ((s[3] | s[1]) && a == 32'h8000_0000 && b == '1)) return 1;
        return W + 2;
    endfunction

    // Called at a falling edge; drives start there and returns at the falling edge where done is seen
    task automatic do_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input int ignore_at);
        logic [W-1:0] got;
        bit seen;
        start = 1; drive_sel(s); operand_a = a; operand_b = b;
        sb.push_back(exp);
        seen = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (k == ignore_at) begin
                start = 1; drive_sel(DIVU); operand_a = $urandom; operand_b = $urandom | 1;
            end else begin
                start = 0; drive_sel(4'b0); operand_a = $urandom; operand_b = $urandom;
            end
            if (done) begin
                seen = 1;
                got = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("done_cycle", W'(k), W'(lat));
                check("busy_at_done", W'(busy), W'(0));
                check("result", result, got);
                last_res = got;
            end else begin
                check("busy_calc", W'(busy), W'(lat > 1));
            end
        end
        if (!seen) check("done_timeout", W'(done), W'(1));
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_single", W'(done), W'(0));
    endtask

    initial begin
        logic [3:0]   ops[4];
        logic [W-1:0] ra, rb;
        bit           saw;
        ops = '{DIV, DIVU, REM, REMU};

        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_result", result, W'(0));
        rst_n = 1;
        @(negedge clk);

        do_op(DIVU, 100, 7, 14, 34, 0);                               idle_check();
        do_op(REMU, 100, 7, 2, 34, 0);                                idle_check();
        do_op(DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34, 0);           idle_check();
        do_op(REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34, 0);           idle_check();
        do_op(REM, 7, 32'hFFFF_FFFE, 1, 34, 0);                       idle_check();
        do_op(DIVU, 5, 0, 32'hFFFF_FFFF, 1, 0);                       idle_check();
        do_op(DIV, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFF, 1, 0);            idle_check();
        do_op(REMU, 5, 0, 5, 1, 0);                                   idle_check();
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0); idle_check();
        do_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0);            idle_check();

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            do_op(ops[i % 4], ra, rb, model(ops[i % 4], ra, rb), lat_of(ops[i % 4], ra, rb), 0);
            idle_check();
        end

        // Back-to-back: each new start lands in the previous done cycle
        do_op(DIV, 1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 34, 0);
        do_op(REMU, 1000, 7, 6, 34, 0);
        do_op(DIVU, 9, 0, 32'hFFFF_FFFF, 1, 0);
        do_op(REMU, 9, 0, 9, 1, 0);
        do_op(DIVU, 1000, 10, 100, 34, 0);
        idle_check();

        // Start pulsed in cycle 5 of a running operation is dropped
        do_op(DIVU, 1000, 10, 100, 34, 5);
        idle_check();
        check("ignored_start_busy", W'(busy), W'(0));

        // Flush at cycle 10, then flush+start together in IDLE
        start = 1; drive_sel(DIVU); operand_a = 1000; operand_b = 3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 0; drive_sel(4'b0);
            if (k == 10) flush = 1;
            check("pre_flush_busy", W'(busy), W'(1));
        end
        @(negedge clk);
        check("flush_busy", W'(busy), W'(0));
        check("flush_done", W'(done), W'(0));
        check("flush_result", result, last_res);
        start = 1; drive_sel(DIVU); operand_a = 5; operand_b = 0;
        @(negedge clk);
        flush = 0;
        check("flush_start_done", W'(done), W'(0));
        check("flush_start_result", result, last_res);
        do_op(DIVU, 1000, 3, 333, 34, 0);
        idle_check();

        // Asynchronous reset in the middle of CALC
        start = 1; drive_sel(DIVU); operand_a = 1000; operand_b = 7;
        repeat (8) begin
            @(negedge clk);
            start = 0; drive_sel(4'b0);
        end
        rst_n = 0;
        #1;
        check("async_reset_busy", W'(busy), W'(0));
        check("async_reset_done", W'(done), W'(0));
        check("async_reset_result", result, W'(0));
        @(negedge clk);
        rst_n = 1;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            saw |= done;
        end
        check("no_done_after_reset", W'(saw), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
